// File: rtl/vga_reg_snapshot_if.sv
`default_nettype none
// ============================================================================
// Module   : vga_reg_snapshot_if
// Brief    : Request/acknowledge read bus between the snapshot controller and
//            the CPU register-file debug port.
// Revision : 1.0 - initial release
// ============================================================================
interface vga_reg_snapshot_if;
  logic        cpu_req;
  logic [4:0]  cpu_addr;
  logic        cpu_ack;
  logic [31:0] cpu_data;

  // Snapshot controller side: issues reads
  modport master (
    output cpu_req,
    output cpu_addr,
    input  cpu_ack,
    input  cpu_data
  );

  // CPU debug port side: answers reads
  modport slave (
    input  cpu_req,
    input  cpu_addr,
    output cpu_ack,
    output cpu_data
  );
endinterface
`default_nettype wire

// File: rtl/vga_reg_snapshot.sv
`default_nettype none
// ============================================================================
// Module   : vga_reg_snapshot
// Brief    : On every vsync assertion, reads all CPU debug registers into a
//            back buffer, then swaps buffers so the VGA debug screen always
//            shows one coherent register set via a zero-latency read port.
// Revision : 1.0 - initial release
// ============================================================================
module vga_reg_snapshot #(
  parameter int   REG_COUNT    = 32,
  parameter logic VSYNC_ACTIVE = 1'b0,
  parameter int   TIMEOUT      = 255
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                vsync,
  vga_reg_snapshot_if.master  bus,
  input  logic [4:0]          regAddr,
  output logic [31:0]         regData,
  output logic                busy,
  output logic                snap_done,
  output logic                overrun,
  output logic                timeout
);

  localparam logic [1:0]  c_ST_IDLE  = 2'd0;
  localparam logic [1:0]  c_ST_REQ   = 2'd1;
  localparam logic [1:0]  c_ST_NEXT  = 2'd2;
  localparam logic [1:0]  c_ST_SWAP  = 2'd3;
  localparam logic [4:0]  c_LAST_IDX = 5'(REG_COUNT - 1);
  localparam logic [7:0]  c_TCNT_MAX = 8'(TIMEOUT - 1);
  localparam logic [31:0] c_FILL     = 32'hDEAD_BEEF;

  logic [1:0]  r_state;
  logic [1:0]  w_state_nxt;
  logic        r_vsync_q;
  logic [4:0]  r_idx;
  logic [7:0]  r_tcnt;
  logic        r_sel;
  logic        r_overrun;
  logic        r_timeout;
  logic [31:0] r_buf [2][32];

  logic w_trig;
  logic w_ack_hit;
  logic w_tmo_hit;
  logic w_last;

  // Frame start is the inactive-to-active transition of vsync
  assign w_trig    = (vsync == VSYNC_ACTIVE) && (r_vsync_q != VSYNC_ACTIVE);
  // A read completes either by acknowledge or by running out of wait budget
  assign w_ack_hit = (r_state == c_ST_REQ) && bus.cpu_ack;
  assign w_tmo_hit = (r_state == c_ST_REQ) && !bus.cpu_ack && (r_tcnt == c_TCNT_MAX);
  assign w_last    = (r_idx == c_LAST_IDX);

  assign overrun = r_overrun;
  assign timeout = r_timeout;

  // State register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= c_ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic: one request per register, then a single swap cycle
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_ST_IDLE: if (w_trig) w_state_nxt = c_ST_REQ;
      c_ST_REQ:  if (w_ack_hit || w_tmo_hit) w_state_nxt = c_ST_NEXT;
      c_ST_NEXT: w_state_nxt = w_last ? c_ST_SWAP : c_ST_REQ;
      c_ST_SWAP: w_state_nxt = c_ST_IDLE;
      default:   w_state_nxt = c_ST_IDLE;
    endcase
  end

  // Output decode: request held for the whole REQ stay, address from index
  always_comb begin
    bus.cpu_req  = 1'b0;
    bus.cpu_addr = r_idx;
    busy         = 1'b1;
    snap_done    = 1'b0;
    case (r_state)
      c_ST_IDLE: busy = 1'b0;
      c_ST_REQ:  bus.cpu_req = 1'b1;
      c_ST_NEXT: bus.cpu_req = 1'b0;
      c_ST_SWAP: snap_done = 1'b1;
      default:   busy = 1'b0;
    endcase
  end

  // Sequencing counters, front-buffer select and sticky status flags
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_vsync_q <= ~VSYNC_ACTIVE;
      r_idx     <= '0;
      r_tcnt    <= '0;
      r_sel     <= 1'b0;
      r_overrun <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_vsync_q <= vsync;
      // A new frame start during a snapshot is flagged but never restarts it
      if (w_trig && (r_state != c_ST_IDLE)) r_overrun <= 1'b1;
      case (r_state)
        c_ST_IDLE: begin
          if (w_trig) begin
            r_idx  <= '0;
            r_tcnt <= '0;
          end
        end
        c_ST_REQ: begin
          if (w_tmo_hit) begin
            r_timeout <= 1'b1;
          end else if (!w_ack_hit) begin
            r_tcnt <= r_tcnt + 8'd1;
          end
        end
        c_ST_NEXT: begin
          if (!w_last) begin
            r_idx  <= r_idx + 5'd1;
            r_tcnt <= '0;
          end
        end
        c_ST_SWAP: r_sel <= ~r_sel;
        default: ;
      endcase
    end
  end

  // Buffer storage: only the back buffer is written, so the front stays coherent
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int b = 0; b < 2; b++) begin
        for (int a = 0; a < 32; a++) begin
          r_buf[b][a] <= '0;
        end
      end
    end else if (w_ack_hit) begin
      r_buf[~r_sel][r_idx] <= bus.cpu_data;
    end else if (w_tmo_hit) begin
      r_buf[~r_sel][r_idx] <= c_FILL;
    end
  end

  // VGA read port: combinational front-buffer lookup, zero beyond REG_COUNT
  generate
    if (REG_COUNT >= 32) begin : g_full_range
      always_comb begin
        regData = r_buf[r_sel][regAddr];
      end
    end else begin : g_part_range
      always_comb begin
        regData = '0;
        if (regAddr < 5'(REG_COUNT)) regData = r_buf[r_sel][regAddr];
      end
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_vga_reg_snapshot.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_reg_snapshot
// Brief    : Self-checking bench for vga_reg_snapshot with a CPU responder,
//            a bus monitor and a per-frame expected-value queue.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vga_reg_snapshot;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        resetn;
  logic        vsync;
  logic [4:0]  regAddr;
  logic [31:0] regData;
  logic        busy;
  logic        snap_done;
  logic        overrun;
  logic        timeout;

  vga_reg_snapshot_if bus ();

  vga_reg_snapshot #(
    .REG_COUNT    (32),
    .VSYNC_ACTIVE (1'b0),
    .TIMEOUT      (TO)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .vsync     (vsync),
    .bus       (bus),
    .regAddr   (regAddr),
    .regData   (regData),
    .busy      (busy),
    .snap_done (snap_done),
    .overrun   (overrun),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] val [32];
  int          dly [32];
  bit          tie_ack = 1'b0;
  int          no_ack = -1;
  logic [31:0] front [32];
  logic [31:0] exp_q [$];
  int          snap_cnt = 0;
  int          req_len [32];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Value the back buffer should hold for address i in the frame being driven
  function automatic logic [31:0] model(input int i);
    if (tie_ack) return val[i];
    if (i == no_ack || dly[i] >= TO) return 32'hDEAD_BEEF;
    return val[i];
  endfunction

  task automatic push_frame();
    for (int i = 0; i < 32; i++) exp_q.push_back(model(i));
  endtask

  task automatic trigger();
    @(negedge clk);
    vsync = 1'b1;
    @(negedge clk);
    vsync = 1'b0;
    @(posedge clk);
  endtask

  // Waits for snap_done (cycle 1 = first cycle after trigger edge), checking
  // the front buffer stays unchanged; returns one cycle after the swap.
  task automatic wait_snap(input int limit, input bit steps, output int cyc);
    bit done = 1'b0;
    cyc = 0;
    while (!done && cyc < limit) begin
      @(negedge clk);
      cyc++;
      regAddr = 5'(cyc % 32);
      #1;
      chk("front_hold", regData, front[cyc % 32]);
      if (steps && cyc <= 64) begin
        chk("req_step", 32'(bus.cpu_req), 32'(cyc % 2));
        if (cyc % 2 == 1) chk("addr_step", 32'(bus.cpu_addr), 32'((cyc - 1) / 2));
      end
      if (snap_done) done = 1'b1;
    end
    chk("snap_seen", 32'(done), 32'd1);
    @(negedge clk);
  endtask

  task automatic check_front();
    logic [31:0] e;
    chk("exp_q_size", 32'(exp_q.size()), 32'd32);
    for (int i = 0; i < 32; i++) begin
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hx;
      regAddr = 5'(i);
      #1;
      chk("front_data", regData, e);
      front[i] = e;
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < 32; i++) front[i] = '0;
    exp_q.delete();
  endtask

  task automatic apply_reset();
    @(negedge clk);
    resetn = 1'b0;
    vsync  = 1'b1;
    clear_model();
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
  endtask

  // CPU responder: acknowledges after dly[addr] wait cycles, or always when tied
  initial begin
    int wc = 0;
    bus.cpu_ack  = 1'b0;
    bus.cpu_data = '0;
    forever begin
      @(negedge clk);
      if (!resetn) begin
        bus.cpu_ack = 1'b0;
        wc = 0;
      end else if (tie_ack) begin
        bus.cpu_ack  = 1'b1;
        bus.cpu_data = val[bus.cpu_addr];
      end else if (bus.cpu_req) begin
        if (int'(bus.cpu_addr) != no_ack && wc == dly[bus.cpu_addr]) begin
          bus.cpu_ack  = 1'b1;
          bus.cpu_data = val[bus.cpu_addr];
        end else begin
          bus.cpu_ack  = 1'b0;
          bus.cpu_data = $urandom;
        end
        wc++;
      end else begin
        bus.cpu_ack = 1'b0;
        wc = 0;
      end
    end
  end

  // Bus monitor: address order, address stability, request lengths, swaps
  initial begin
    bit         prev_req = 1'b0;
    logic [4:0] prev_addr = '0;
    int         run = 0;
    int         exp_addr = 0;
    forever begin
      @(negedge clk);
      if (!resetn) begin
        prev_req = 1'b0;
        run = 0;
        exp_addr = 0;
      end else begin
        if (snap_done) snap_cnt++;
        if (bus.cpu_req && !prev_req) begin
          chk("addr_seq", 32'(bus.cpu_addr), 32'(exp_addr));
          exp_addr = (exp_addr + 1) % 32;
          run = 1;
        end else if (bus.cpu_req) begin
          chk("addr_stable", 32'(bus.cpu_addr), 32'(prev_addr));
          run++;
        end else if (prev_req) begin
          req_len[prev_addr] = run;
        end
        prev_req  = bus.cpu_req;
        prev_addr = bus.cpu_addr;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int k;
    int sc0;
    bit exp_to;
    resetn  = 1'b0;
    vsync   = 1'b1;
    regAddr = '0;
    for (int i = 0; i < 32; i++) begin
      val[i] = '0;
      dly[i] = 0;
      req_len[i] = 0;
    end
    clear_model();

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_snap_done", 32'(snap_done), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    chk("rst_timeout", 32'(timeout), 32'd0);
    chk("rst_cpu_req", 32'(bus.cpu_req), 32'd0);
    for (int i = 0; i < 32; i++) begin
      regAddr = 5'(i);
      #1;
      chk("rst_regData", regData, 32'd0);
    end
    @(negedge clk);
    resetn = 1'b1;
    repeat (5) @(negedge clk);
    chk("idle_cpu_req", 32'(bus.cpu_req), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);

    // Ack tied high: fixed 2-cycle-per-register cadence
    for (int i = 0; i < 32; i++) val[i] = 32'h1000_0000 + 32'(i);
    tie_ack = 1'b1;
    push_frame();
    trigger();
    wait_snap(200, 1'b1, cyc);
    chk("snap_latency", 32'(cyc), 32'd65);
    check_front();
    regAddr = 5'd5;
    #1;
    chk("regData5", regData, 32'h1000_0005);
    repeat (20) @(negedge clk);
    chk("held_vsync_once", 32'(snap_cnt), 32'd1);
    chk("held_vsync_idle", 32'(busy), 32'd0);
    chk("tied_overrun", 32'(overrun), 32'd0);
    chk("tied_timeout", 32'(timeout), 32'd0);
    tie_ack = 1'b0;

    // Random ack delays 0..10, values changing each frame
    exp_to = 1'b0;
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < 32; i++) begin
        val[i] = $urandom;
        dly[i] = $urandom_range(0, 10);
        if (dly[i] >= TO) exp_to = 1'b1;
      end
      push_frame();
      trigger();
      wait_snap(400, 1'b0, cyc);
      check_front();
      chk("rand_timeout", 32'(timeout), 32'(exp_to));
    end

    // Address 3 never acknowledged
    apply_reset();
    for (int i = 0; i < 32; i++) begin
      val[i] = 32'hA000_0000 + 32'(i * 3);
      dly[i] = 0;
    end
    no_ack = 3;
    push_frame();
    trigger();
    wait_snap(400, 1'b0, cyc);
    check_front();
    chk("to_req_len3", 32'(req_len[3]), 32'(TO));
    chk("to_req_len2", 32'(req_len[2]), 32'd1);
    chk("to_timeout", 32'(timeout), 32'd1);
    chk("to_overrun", 32'(overrun), 32'd0);
    no_ack = -1;

    // Second vsync assertion while busy
    for (int i = 0; i < 32; i++) val[i] = ~(32'h0F0F_0000 + 32'(i));
    push_frame();
    sc0 = snap_cnt;
    trigger();
    repeat (20) @(negedge clk);
    chk("overrun_pre", 32'(overrun), 32'd0);
    vsync = 1'b1;
    @(negedge clk);
    vsync = 1'b0;
    wait_snap(200, 1'b0, cyc);
    check_front();
    chk("overrun_set", 32'(overrun), 32'd1);
    repeat (100) @(negedge clk);
    chk("overrun_one_snap", 32'(snap_cnt - sc0), 32'd1);
    chk("overrun_idle", 32'(busy), 32'd0);

    // Reset in the middle of a snapshot at index 10
    for (int i = 0; i < 32; i++) val[i] = 32'h5000_0000 ^ 32'(i << 8);
    sc0 = snap_cnt;
    trigger();
    k = 0;
    while (!(bus.cpu_req && bus.cpu_addr == 5'd10) && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("reach_idx10", 32'(bus.cpu_addr), 32'd10);
    resetn = 1'b0;
    vsync  = 1'b1;
    #1;
    chk("mid_rst_req", 32'(bus.cpu_req), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    clear_model();
    repeat (2) @(negedge clk);
    chk("mid_rst_snap_done", 32'(snap_done), 32'd0);
    for (int i = 0; i <= 10; i++) begin
      regAddr = 5'(i);
      #1;
      chk("mid_rst_regData", regData, 32'd0);
    end
    resetn = 1'b1;
    repeat (80) @(negedge clk);
    chk("mid_rst_no_snap", 32'(snap_cnt - sc0), 32'd0);
    chk("mid_rst_idle", 32'(busy), 32'd0);
    push_frame();
    trigger();
    wait_snap(200, 1'b1, cyc);
    chk("post_rst_latency", 32'(cyc), 32'd65);
    check_front();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/vga_reg_snapshot.md
# vga_reg_snapshot

Snapshot controller between the CPU register-file debug read port and the VGA debug screen. At every frame start (vsync assertion) it sequences a read of all CPU registers via a req/ack handshake into a back buffer, then swaps buffers so the screen always shows one coherent register set. The VGA side reads the front buffer combinationally by `regAddr`, so the debug screen's `regData` input is served from this block rather than directly from the CPU.

## Interface
- `REG_COUNT`, 32: registers per snapshot (1..32); addresses 0..REG_COUNT-1.
- `VSYNC_ACTIVE`, 1'b0: active level of `vsync`.
- `TIMEOUT`, 255: maximum cycles to wait for `cpu_ack` per read (1..255).
- `clk` in 1: single clock, shared with the VGA unit.
- `resetn` in 1: asynchronous, active-low reset.
- `vsync` in 1: from the VGA timing unit, same clock domain.
- `cpu_req` out 1: read request to the CPU debug port.
- `cpu_addr` out 5: register address; valid while `cpu_req`=1.
- `cpu_ack` in 1: read accepted; `cpu_data` valid in the same cycle.
- `cpu_data` in 32: register value.
- `regAddr` in 5: VGA read address.
- `regData` out 32: front-buffer word at `regAddr`, combinational. Addresses ≥ REG_COUNT return 0.
- `busy` out 1: snapshot in progress.
- `snap_done` out 1: one-cycle pulse when a buffer swap occurs.
- `overrun` out 1: sticky; a trigger arrived while busy.
- `timeout` out 1: sticky; at least one read timed out.

## Operation
- Two 32x32 buffers plus `sel` (front-buffer index). Reset clears both buffers, `sel`=0, and every output to 0. `regData` therefore reads 0 until the first swap.
- Trigger: `vsync_q` is `vsync` registered. Trigger = (`vsync`==VSYNC_ACTIVE) && (`vsync_q`!=VSYNC_ACTIVE). After reset, `vsync_q` resets to !VSYNC_ACTIVE, so a held-active `vsync` triggers once.
- FSM states: IDLE, REQ, NEXT, SWAP.
  - IDLE: on trigger, go to REQ with `idx`=0 and `tcnt`=0.
  - REQ: `cpu_req`=1 and `cpu_addr`=`idx`, held stable.
    - On a clock edge with `cpu_ack`=1, write `cpu_data` to back[`idx`] and go to NEXT.
    - Otherwise, if `tcnt`==TIMEOUT-1, write 32'hDEADBEEF to back[`idx`], set `timeout`, and go to NEXT.
    - Otherwise increment `tcnt`.
  - NEXT: `cpu_req`=0 for exactly one cycle.
    - If `idx`==REG_COUNT-1, go to SWAP.
    - Otherwise increment `idx`, clear `tcnt`, and go to REQ.
  - SWAP: toggle `sel`, assert `snap_done` for this cycle, and go to IDLE.
- `busy`=1 in REQ, NEXT and SWAP.
- A trigger seen in any state other than IDLE sets `overrun` and is otherwise ignored. The snapshot in progress is neither restarted nor aborted.
- `cpu_ack` is ignored outside REQ.
- Only the back buffer (index !`sel`) is ever written. The front buffer is never modified between swaps.
- `overrun` and `timeout` clear only on reset.
- Reset mid-snapshot: all state returns to reset values immediately. The partial back buffer is cleared, and no swap or `snap_done` occurs.

## Timing
- Trigger edge at cycle T: `vsync` samples active at T while `vsync_q` is inactive. Then `cpu_req`=1 with `cpu_addr`=0 from cycle T+1.
- Each read takes (ack wait + 1) cycles in REQ plus 1 cycle in NEXT. With `cpu_ack` tied high that is 2 cycles per register.
- With `cpu_ack` tied high and REG_COUNT=32:
  - last read completes at T+64;
  - SWAP occurs in cycle T+65, with `snap_done`=1 in that cycle;
  - new `regData` is visible from T+66.
- A timed-out read occupies exactly TIMEOUT cycles in REQ.
- `regData` has zero latency from `regAddr`.

## Test plan
- Reset with `cpu_ack`=0, `vsync` inactive: all outputs 0, `regData`=0 for every `regAddr`, `cpu_req` stays 0.
- `cpu_data`=32'h1000_0000+addr, `cpu_ack` tied 1, one vsync assertion: `cpu_addr` steps 0..31 on alternate cycles; `snap_done` pulses at T+65; afterwards `regAddr`=5 → `regData`=32'h1000_0005.
- Random 0–10-cycle ack delay with values changed between frames: `cpu_addr` holds stable while `cpu_req`=1. `regData` keeps the old frame's values until `snap_done`, then shows only new values, never a mix.
- Ack never given at address 3, TIMEOUT=8: REQ at address 3 lasts 8 cycles; `regData`[3]=32'hDEADBEEF after swap; `timeout`=1; other addresses hold correct values.
- Second vsync assertion while `busy`: `overrun`=1; the snapshot in progress completes; exactly one `snap_done`.
- `resetn` pulsed low while `idx`=10: `cpu_req` drops immediately; `busy`=0; no `snap_done`; `regData`=0; the next vsync runs a full snapshot from address 0.
